// File: rtl/cpu_loader_pkg.sv
// Shared constants for the serial boot loader: host command/reply codes and FSM encoding.
package cpu_loader_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned CNT_W   = 9;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_READ = 8'h52;
    localparam logic [7:0] CMD_GO   = 8'h47;

    localparam logic [7:0] RSP_OK   = 8'h4B;
    localparam logic [7:0] RSP_HALT = 8'h48;
    localparam logic [7:0] RSP_ERR  = 8'h3F;

    localparam logic [STATE_W-1:0] ST_IDLE  = 4'd0;
    localparam logic [STATE_W-1:0] ST_ADRH  = 4'd1;
    localparam logic [STATE_W-1:0] ST_ADRL  = 4'd2;
    localparam logic [STATE_W-1:0] ST_LEN   = 4'd3;
    localparam logic [STATE_W-1:0] ST_LDATA = 4'd4;
    localparam logic [STATE_W-1:0] ST_RREQ  = 4'd5;
    localparam logic [STATE_W-1:0] ST_RWAIT = 4'd6;
    localparam logic [STATE_W-1:0] ST_RSAMP = 4'd7;
    localparam logic [STATE_W-1:0] ST_RSEND = 4'd8;
    localparam logic [STATE_W-1:0] ST_GO    = 4'd9;
    localparam logic [STATE_W-1:0] ST_RUN   = 4'd10;
    localparam logic [STATE_W-1:0] ST_TX    = 4'd11;
    localparam logic [STATE_W-1:0] ST_GUARD = 4'd12;

    // True for command bytes that are followed by an address.
    function automatic logic is_cmd(input logic [7:0] b);
        return (b == CMD_LOAD) || (b == CMD_READ) || (b == CMD_GO);
    endfunction

endpackage

// File: rtl/bus_owner_mux.sv
// Steers RAM and UART between the loader and the CPU; sel=1 hands both to the CPU.
module bus_owner_mux #(
    parameter int unsigned ADDR_W = 9
) (
    input  logic              sel,
    input  logic [ADDR_W-1:0] ld_raddr,
    input  logic [ADDR_W-1:0] ld_waddr,
    input  logic [7:0]        ld_wdata,
    input  logic              ld_we,
    input  logic [7:0]        ld_tx_byte,
    input  logic              ld_tx_transmit,
    input  logic [ADDR_W-1:0] cpu_raddr,
    input  logic [ADDR_W-1:0] cpu_waddr,
    input  logic [7:0]        cpu_wdata,
    input  logic              cpu_we,
    input  logic [7:0]        cpu_tx_byte,
    input  logic              cpu_transmit,
    input  logic              rx_received,
    input  logic [7:0]        rx_byte,
    input  logic              tx_is_transmitting,
    output logic [ADDR_W-1:0] ram_raddr_c,
    output logic [ADDR_W-1:0] ram_waddr_c,
    output logic [7:0]        ram_wdata_c,
    output logic              ram_we_c,
    output logic [7:0]        tx_byte_c,
    output logic              tx_transmit_c,
    output logic              cpu_is_transmitting_c,
    output logic              cpu_received_c,
    output logic [7:0]        cpu_rx_byte_c
);

    assign ram_raddr_c   = sel ? cpu_raddr    : ld_raddr;
    assign ram_waddr_c   = sel ? cpu_waddr    : ld_waddr;
    assign ram_wdata_c   = sel ? cpu_wdata    : ld_wdata;
    assign ram_we_c      = sel ? cpu_we       : ld_we;
    assign tx_byte_c     = sel ? cpu_tx_byte  : ld_tx_byte;
    assign tx_transmit_c = sel ? cpu_transmit : ld_tx_transmit;

    // A stopped CPU sees a permanently busy UART and no received bytes.
    assign cpu_is_transmitting_c = sel ? tx_is_transmitting : 1'b1;
    assign cpu_received_c        = sel & rx_received;
    assign cpu_rx_byte_c         = sel ? rx_byte : 8'd0;

endmodule

// File: rtl/cpu_loader.sv
// Serial boot/monitor controller: loads and reads RAM over UART, starts the CPU and
// reclaims RAM/UART when the CPU halts.
module cpu_loader
    import cpu_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_received,
    input  logic [7:0]        rx_byte,
    input  logic              tx_is_transmitting,
    output logic [7:0]        tx_byte,
    output logic              tx_transmit,
    output logic [ADDR_W-1:0] ram_raddr,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [7:0]        ram_wdata,
    output logic              ram_we,
    input  logic [7:0]        ram_rdata,
    input  logic [ADDR_W-1:0] cpu_raddr,
    input  logic [ADDR_W-1:0] cpu_waddr,
    input  logic [7:0]        cpu_wdata,
    input  logic              cpu_we,
    input  logic [7:0]        cpu_tx_byte,
    input  logic              cpu_transmit,
    output logic              cpu_is_transmitting,
    output logic              cpu_received,
    output logic [7:0]        cpu_rx_byte,
    input  logic              cpu_halted,
    output logic              cpu_go,
    output logic [ADDR_W-1:0] cpu_startaddr,
    output logic              running
);

    logic [STATE_W-1:0] state_q,     state_d;
    logic [STATE_W-1:0] ret_q,       ret_d;
    logic [7:0]         cmd_q,       cmd_d;
    logic [7:0]         addr_hi_q,   addr_hi_d;
    logic [ADDR_W-1:0]  addr_q,      addr_d;
    logic [CNT_W-1:0]   count_q,     count_d;
    logic [7:0]         tx_byte_q,   tx_byte_d;
    logic               tx_send_q,   tx_send_d;
    logic [ADDR_W-1:0]  raddr_q,     raddr_d;
    logic [ADDR_W-1:0]  waddr_q,     waddr_d;
    logic [7:0]         wdata_q,     wdata_d;
    logic               we_q,        we_d;
    logic               go_q,        go_d;
    logic [ADDR_W-1:0]  startaddr_q, startaddr_d;
    logic               run_q,       run_d;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ret_q       <= ST_IDLE;
            cmd_q       <= 8'd0;
            addr_hi_q   <= 8'd0;
            addr_q      <= '0;
            count_q     <= '0;
            tx_byte_q   <= 8'd0;
            tx_send_q   <= 1'b0;
            raddr_q     <= '0;
            waddr_q     <= '0;
            wdata_q     <= 8'd0;
            we_q        <= 1'b0;
            go_q        <= 1'b0;
            startaddr_q <= '0;
            run_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            cmd_q       <= cmd_d;
            addr_hi_q   <= addr_hi_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            tx_byte_q   <= tx_byte_d;
            tx_send_q   <= tx_send_d;
            raddr_q     <= raddr_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            go_q        <= go_d;
            startaddr_q <= startaddr_d;
            run_q       <= run_d;
        end
    end

    // Next-state and register-input logic; TX/GUARD resume at ret_q once the reply is out.
    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        cmd_d       = cmd_q;
        addr_hi_d   = addr_hi_q;
        addr_d      = addr_q;
        count_d     = count_q;
        tx_byte_d   = tx_byte_q;
        tx_send_d   = 1'b0;
        raddr_d     = raddr_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        we_d        = 1'b0;
        go_d        = 1'b0;
        startaddr_d = startaddr_q;
        run_d       = run_q;

        case (state_q)
            ST_IDLE: begin
                if (rx_received) begin
                    cmd_d = rx_byte;
                    if (is_cmd(rx_byte)) begin
                        state_d = ST_ADRH;
                    end else begin
                        tx_byte_d = RSP_ERR;
                        ret_d     = ST_IDLE;
                        state_d   = ST_TX;
                    end
                end
            end
            ST_ADRH: begin
                if (rx_received) begin
                    addr_hi_d = rx_byte;
                    state_d   = ST_ADRL;
                end
            end
            ST_ADRL: begin
                if (rx_received) begin
                    addr_d = ADDR_W'({addr_hi_q, rx_byte});
                    if (cmd_q == CMD_GO) begin
                        startaddr_d = ADDR_W'({addr_hi_q, rx_byte});
                        go_d        = 1'b1;
                        run_d       = 1'b1;
                        state_d     = ST_GO;
                    end else begin
                        state_d = ST_LEN;
                    end
                end
            end
            ST_LEN: begin
                if (rx_received) begin
                    count_d = (rx_byte == 8'd0) ? CNT_W'(256) : CNT_W'(rx_byte);
                    state_d = (cmd_q == CMD_LOAD) ? ST_LDATA : ST_RREQ;
                end
            end
            ST_LDATA: begin
                if (rx_received) begin
                    we_d    = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = rx_byte;
                    addr_d  = addr_q + ADDR_W'(1);
                    count_d = count_q - CNT_W'(1);
                    if (count_q == CNT_W'(1)) begin
                        tx_byte_d = RSP_OK;
                        ret_d     = ST_IDLE;
                        state_d   = ST_TX;
                    end
                end
            end
            ST_RREQ: begin
                raddr_d = addr_q;
                state_d = ST_RWAIT;
            end
            ST_RWAIT: begin
                state_d = ST_RSAMP;
            end
            ST_RSAMP: begin
                tx_byte_d = ram_rdata;
                state_d   = ST_RSEND;
            end
            ST_RSEND: begin
                // A zero count here means the data bytes are done and only 'K' remains.
                if (count_q == '0) begin
                    tx_byte_d = RSP_OK;
                    ret_d     = ST_IDLE;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    count_d = count_q - CNT_W'(1);
                    ret_d   = (count_q == CNT_W'(1)) ? ST_RSEND : ST_RREQ;
                end
                state_d = ST_TX;
            end
            ST_GO: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (cpu_halted) begin
                    run_d     = 1'b0;
                    tx_byte_d = RSP_HALT;
                    ret_d     = ST_IDLE;
                    state_d   = ST_TX;
                end
            end
            ST_TX: begin
                if (!tx_is_transmitting) begin
                    tx_send_d = 1'b1;
                    state_d   = ST_GUARD;
                end
            end
            ST_GUARD: begin
                state_d = ret_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset revokes CPU ownership in the same cycle, before the register clears.
    assign running       = run_q & ~rst;
    assign cpu_go        = go_q;
    assign cpu_startaddr = startaddr_q;

    bus_owner_mux #(.ADDR_W(ADDR_W)) u_mux (
        .sel                   (running),
        .ld_raddr              (raddr_q),
        .ld_waddr              (waddr_q),
        .ld_wdata              (wdata_q),
        .ld_we                 (we_q),
        .ld_tx_byte            (tx_byte_q),
        .ld_tx_transmit        (tx_send_q),
        .cpu_raddr             (cpu_raddr),
        .cpu_waddr             (cpu_waddr),
        .cpu_wdata             (cpu_wdata),
        .cpu_we                (cpu_we),
        .cpu_tx_byte           (cpu_tx_byte),
        .cpu_transmit          (cpu_transmit),
        .rx_received           (rx_received),
        .rx_byte               (rx_byte),
        .tx_is_transmitting    (tx_is_transmitting),
        .ram_raddr_c           (ram_raddr),
        .ram_waddr_c           (ram_waddr),
        .ram_wdata_c           (ram_wdata),
        .ram_we_c              (ram_we),
        .tx_byte_c             (tx_byte),
        .tx_transmit_c         (tx_transmit),
        .cpu_is_transmitting_c (cpu_is_transmitting),
        .cpu_received_c        (cpu_received),
        .cpu_rx_byte_c         (cpu_rx_byte)
    );

endmodule
